// File: rtl/dram_load_sequencer.sv
// Diagnostic loader for the IR board's 512-entry dispatch RAM: IR load, DRADR latch, then 06X strobes.
// Optional DRAM_VERIFY_EN adds RDAB/RDJ read-back with a sticky err flag.
module dram_load_sequencer #(
    parameter int unsigned STROBE_W = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [8:0]  reqAddr,
    input  logic [2:0]  reqA,
    input  logic [2:0]  reqB,
    input  logic [10:0] reqJ,
    input  logic        reqJcom,
    input  logic        abort,
    output logic [12:0] irData,
    output logic        loadIR,
    output logic        loadDRAM,
    output logic [2:0]  diagFunc,
    output logic        diagLoadFunc06X,
    output logic        diagReadFunc13X,
    output logic [5:0]  ebusOut,
    output logic        ebusOE,
    input  logic [5:0]  ebusIn,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {
        S_IDLE, S_LDIR, S_LDDR, S_SET, S_STB, S_HOLD, S_RDAB, S_RDJ, S_DONE
    } state_e;
    typedef enum logic [1:0] {ST_XY, ST_JCOM, ST_JHALF} step_e;

    localparam logic [3:0] STB_LAST = 4'(STROBE_W - 1);
    localparam logic [3:0] STB_MAX  = 4'(STROBE_W);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  addr_q;
    logic [5:0]  ab_q;
    logic [3:0]  jcom_q, jhalf_q;
    logic        jcomEn_q;
    logic        accept;
    logic [2:0]  stepFunc;
    logic [5:0]  stepData;

    assign accept = reqValid && (state_q == S_IDLE);

    // Bit numbering is MSB-first (IR[0:8], J[0:10], EBUS[0:5]): IR[8] is the
    // LSB, J[1:4] is reqJ[9:6] and J[7:10] is reqJ[3:0].
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            step_q   <= ST_XY;
            cnt_q    <= '0;
            addr_q   <= '0;
            ab_q     <= '0;
            jcom_q   <= '0;
            jhalf_q  <= '0;
            jcomEn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= reqAddr;
                ab_q     <= {reqA, reqB};
                jcom_q   <= reqJ[9:6];
                jhalf_q  <= reqJ[3:0];
                jcomEn_q <= reqJcom;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_LDIR;
            S_LDIR: state_d = S_LDDR;
            S_LDDR: begin
                state_d = S_SET;
                step_d  = ST_XY;
            end
            S_SET: begin
                state_d = S_STB;
                cnt_d   = '0;
            end
            S_STB: begin
                cnt_d = (cnt_q == STB_MAX) ? cnt_q : cnt_q + 4'd1;
                if (cnt_q >= STB_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                case (step_q)
                    ST_XY: begin
                        state_d = S_SET;
                        step_d  = jcomEn_q ? ST_JCOM : ST_JHALF;
                    end
                    ST_JCOM: begin
                        state_d = S_SET;
                        step_d  = ST_JHALF;
                    end
                    default: begin
`ifdef DRAM_VERIFY_EN
                        state_d = S_RDAB;
                        cnt_d   = '0;
`else
                        state_d = S_DONE;
`endif
                    end
                endcase
            end
            S_RDAB: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RDJ;
                    cnt_d   = '0;
                end
            end
            S_RDJ: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        stepFunc = 3'b000;
        stepData = '0;
        case (step_q)
            ST_XY: begin
                stepFunc = addr_q[0] ? 3'b001 : 3'b000;
                stepData = ab_q;
            end
            ST_JCOM: begin
                stepFunc = 3'b010;
                stepData = {2'b00, jcom_q};
            end
            default: begin
                stepFunc = addr_q[0] ? 3'b100 : 3'b011;
                stepData = {2'b00, jhalf_q};
            end
        endcase
    end

    always_comb begin
        reqReady        = (state_q == S_IDLE);
        busy            = (state_q != S_IDLE);
        loadIR          = (state_q == S_LDIR);
        loadDRAM        = (state_q == S_LDDR);
        done            = (state_q == S_DONE);
        diagLoadFunc06X = (state_q == S_STB);
        diagReadFunc13X = 1'b0;
        ebusOE          = 1'b0;
        ebusOut         = '0;
        diagFunc        = 3'b000;
        case (state_q)
            S_SET, S_STB, S_HOLD: begin
                ebusOE   = 1'b1;
                ebusOut  = stepData;
                diagFunc = stepFunc;
            end
`ifdef DRAM_VERIFY_EN
            S_RDAB: begin
                diagReadFunc13X = 1'b1;
                diagFunc        = 3'b011;
            end
            S_RDJ: begin
                diagReadFunc13X = 1'b1;
                diagFunc        = 3'b101;
            end
`endif
            default: ;
        endcase
    end

    assign irData = {addr_q, 4'b0000};

`ifdef DRAM_VERIFY_EN
    logic err_q;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (!abort && cnt_q == 4'd1) begin
            if (state_q == S_RDAB && ebusIn != ab_q)       err_q <= 1'b1;
            if (state_q == S_RDJ  && ebusIn[3:0] != jhalf_q) err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // J[0] and J[5:6] are never written; ebusIn only matters with read-back.
    logic unused_inputs;
    assign unused_inputs = ^{ebusIn, reqJ[10], reqJ[5:4]};

endmodule

// File: tb/tb_dram_load_sequencer.sv
// Directed bench for dram_load_sequencer (STROBE_W = 2); honours DRAM_VERIFY_EN.
module tb_dram_load_sequencer;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        reqValid = 1'b0, reqJcom = 1'b0, abort = 1'b0;
    logic [8:0]  reqAddr = '0;
    logic [2:0]  reqA = '0, reqB = '0;
    logic [10:0] reqJ = '0;
    logic        reqReady, loadIR, loadDRAM, diagLoadFunc06X, diagReadFunc13X, ebusOE, busy, done, err;
    logic [12:0] irData;
    logic [2:0]  diagFunc;
    logic [5:0]  ebusOut, ebusIn;
    logic [5:0]  rdAB = '0, rdJ = '0;

`ifdef DRAM_VERIFY_EN
    localparam int VX = 4;
`else
    localparam int VX = 0;
`endif

    int nvec = 0, nfail = 0;

    // Captured per run by watch()
    int cDoneCyc, cDoneCnt, cLdirCyc, cLddrCyc, cOeCnt, cStbCnt, cRdCnt, cRdyCyc, cBadOe;
    logic [12:0] cIrData;
    logic cErrDone, cErrC1;
    logic [2:0] cFunc[$];
    logic [5:0] cEbus[$];

    always #5 clk = ~clk;

    // Read-back responder: RDAB returns rdAB, RDJ returns rdJ
    assign ebusIn = !diagReadFunc13X ? 6'h00 : (diagFunc == 3'b011) ? rdAB : rdJ;

    dram_load_sequencer #(.STROBE_W(2)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqA(reqA), .reqB(reqB), .reqJ(reqJ), .reqJcom(reqJcom),
        .abort(abort), .irData(irData), .loadIR(loadIR), .loadDRAM(loadDRAM),
        .diagFunc(diagFunc), .diagLoadFunc06X(diagLoadFunc06X), .diagReadFunc13X(diagReadFunc13X),
        .ebusOut(ebusOut), .ebusOE(ebusOE), .ebusIn(ebusIn), .busy(busy), .done(done), .err(err)
    );

    // Presents one request, returns just after the accepting edge (T0), then scrambles inputs.
    task automatic send(input logic [8:0] a9, input logic [2:0] fa, input logic [2:0] fb,
                        input logic [10:0] fj, input logic jc);
        @(negedge clk);
        reqAddr = a9; reqA = fa; reqB = fb; reqJ = fj; reqJcom = jc; reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        reqAddr = 9'h1FF; reqA = 3'd0; reqB = 3'd0; reqJ = 11'h7FF; reqJcom = ~jc;
    endtask

    // Samples ncyc cycles after T0 at the falling edge; optionally drives abort/reqValid.
    task automatic watch(input int ncyc, input int abortAt, input int vFrom, input int vTo);
        logic prevStb;
        prevStb = 1'b0;
        cDoneCyc = -1; cDoneCnt = 0; cLdirCyc = -1; cLddrCyc = -1; cOeCnt = 0; cStbCnt = 0;
        cRdCnt = 0; cRdyCyc = -1; cBadOe = 0; cIrData = '0; cErrDone = 1'bx; cErrC1 = 1'bx;
        cFunc.delete(); cEbus.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) cErrC1 = err;
            if (loadIR) begin cLdirCyc = c; cIrData = irData; end
            if (loadDRAM) cLddrCyc = c;
            if (ebusOE) cOeCnt++;
            if (diagLoadFunc06X) begin
                cStbCnt++;
                if (!ebusOE) cBadOe++;
                if (!prevStb) begin cFunc.push_back(diagFunc); cEbus.push_back(ebusOut); end
            end
            prevStb = diagLoadFunc06X;
            if (diagReadFunc13X) cRdCnt++;
            if (reqReady && cRdyCyc < 0) cRdyCyc = c;
            if (done) begin
                cDoneCnt++;
                if (cDoneCyc < 0) begin cDoneCyc = c; cErrDone = err; end
            end
            abort = (c == abortAt);
            reqValid = (c >= vFrom && c <= vTo);
        end
        abort = 1'b0; reqValid = 1'b0;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        #12;
        nvec++; if (reqReady !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", reqReady); end
        nvec++; if ({busy, loadIR, loadDRAM, diagLoadFunc06X, diagReadFunc13X, ebusOE, done, err} !== 8'h00)
            begin nfail++; $display("FAIL reset_outs: got %b want 00000000", {busy, loadIR, loadDRAM, diagLoadFunc06X, diagReadFunc13X, ebusOE, done, err}); end
        nvec++; if ({irData, diagFunc, ebusOut} !== 22'h0) begin nfail++; $display("FAIL reset_data: got %h want 0", {irData, diagFunc, ebusOut}); end
        @(negedge clk) resetN = 1'b1;
    endtask

    // addr 0x054 even, A=5 B=3, J=0x2A5 with J-common.
    // irData = {0x054,4'b0} = 0x540; XY {101,011}=0x2B; J[1:4]=reqJ[9:6]=1010 -> 0x0A; J[7:10]=reqJ[3:0]=0101 -> 0x05
    task automatic test_even_jcom;
        rdAB = 6'h2B; rdJ = 6'h05;
        send(9'h054, 3'd5, 3'd3, 11'h2A5, 1'b1);
        watch(20, 0, 0, -1);
        nvec++; if (cLdirCyc !== 1 || cIrData !== 13'h0540) begin nfail++; $display("FAIL even_ldir: got cyc %0d ir %h want cyc 1 ir 0540", cLdirCyc, cIrData); end
        nvec++; if (cLddrCyc !== 2) begin nfail++; $display("FAIL even_lddr: got cyc %0d want 2", cLddrCyc); end
        nvec++; if (cFunc.size() !== 3) begin nfail++; $display("FAIL even_nsteps: got %0d want 3", cFunc.size()); end
        else begin
            nvec++; if ({cFunc[0], cFunc[1], cFunc[2]} !== {3'b000, 3'b010, 3'b011})
                begin nfail++; $display("FAIL even_funcs: got %b %b %b want 000 010 011", cFunc[0], cFunc[1], cFunc[2]); end
            nvec++; if ({cEbus[0], cEbus[1], cEbus[2]} !== {6'h2B, 6'h0A, 6'h05})
                begin nfail++; $display("FAIL even_ebus: got %h %h %h want 2b 0a 05", cEbus[0], cEbus[1], cEbus[2]); end
        end
        nvec++; if (cStbCnt !== 6 || cOeCnt !== 12 || cBadOe !== 0) begin nfail++; $display("FAIL even_strobe_oe: got stb %0d oe %0d bad %0d want 6 12 0", cStbCnt, cOeCnt, cBadOe); end
        nvec++; if (cDoneCyc !== 15 + VX || cDoneCnt !== 1) begin nfail++; $display("FAIL even_done: got cyc %0d cnt %0d want %0d 1", cDoneCyc, cDoneCnt, 15 + VX); end
        nvec++; if (cRdCnt !== VX || cErrDone !== 1'b0) begin nfail++; $display("FAIL even_read_err: got rd %0d err %b want %0d 0", cRdCnt, cErrDone, VX); end
        nvec++; if (cRdyCyc !== 16 + VX) begin nfail++; $display("FAIL even_ready: got %0d want %0d", cRdyCyc, 16 + VX); end
    endtask

    // addr 0x055 odd, A=2 B=7 -> 0x17, J=0x3C9 -> J[7:10]=1001 -> 0x09, no J-common
    task automatic test_odd_nojcom(input string tag);
        rdAB = 6'h17; rdJ = 6'h09;
        send(9'h055, 3'd2, 3'd7, 11'h3C9, 1'b0);
        watch(16, 0, 0, -1);
        nvec++; if (cIrData !== 13'h0550) begin nfail++; $display("FAIL %s_irdata: got %h want 0550", tag, cIrData); end
        nvec++; if (cFunc.size() !== 2) begin nfail++; $display("FAIL %s_nsteps: got %0d want 2", tag, cFunc.size()); end
        else begin
            nvec++; if ({cFunc[0], cFunc[1], cEbus[0], cEbus[1]} !== {3'b001, 3'b100, 6'h17, 6'h09})
                begin nfail++; $display("FAIL %s_steps: got %b %b %h %h want 001 100 17 09", tag, cFunc[0], cFunc[1], cEbus[0], cEbus[1]); end
        end
        nvec++; if (cDoneCyc !== 11 + VX || cDoneCnt !== 1) begin nfail++; $display("FAIL %s_done: got cyc %0d cnt %0d want %0d 1", tag, cDoneCyc, cDoneCnt, 11 + VX); end
        nvec++; if (cErrC1 !== 1'b0 || cErrDone !== 1'b0) begin nfail++; $display("FAIL %s_err: got c1 %b done %b want 0 0", tag, cErrC1, cErrDone); end
    endtask

    // Abort on the first STB cycle (cycle 4): IDLE from cycle 5, no done.
    task automatic test_abort;
        send(9'h054, 3'd5, 3'd3, 11'h2A5, 1'b1);
        watch(20, 4, 0, -1);
        nvec++; if (cStbCnt !== 1 || cOeCnt !== 2) begin nfail++; $display("FAIL abort_strobe: got stb %0d oe %0d want 1 2", cStbCnt, cOeCnt); end
        nvec++; if (cRdyCyc !== 5) begin nfail++; $display("FAIL abort_idle: got ready cyc %0d want 5", cRdyCyc); end
        nvec++; if (cDoneCnt !== 0) begin nfail++; $display("FAIL abort_nodone: got %0d want 0", cDoneCnt); end
        test_odd_nojcom("after_abort");
    endtask

    // reqValid pulsed (with scrambled fields) while busy: must be ignored.
    task automatic test_busy_ignore;
        rdAB = 6'h2B; rdJ = 6'h05;
        send(9'h054, 3'd5, 3'd3, 11'h2A5, 1'b1);
        watch(40, 0, 5, 9);
        nvec++; if (cDoneCnt !== 1 || cDoneCyc !== 15 + VX) begin nfail++; $display("FAIL busy_done: got cnt %0d cyc %0d want 1 %0d", cDoneCnt, cDoneCyc, 15 + VX); end
        nvec++; if (cFunc.size() !== 3) begin nfail++; $display("FAIL busy_nsteps: got %0d want 3", cFunc.size()); end
        else begin
            nvec++; if ({cEbus[0], cEbus[1], cEbus[2]} !== {6'h2B, 6'h0A, 6'h05})
                begin nfail++; $display("FAIL busy_ebus: got %h %h %h want 2b 0a 05", cEbus[0], cEbus[1], cEbus[2]); end
        end
    endtask

    // Async reset during the JHALF strobe (cycle 12 of a J-common write).
    task automatic test_async_reset;
        send(9'h054, 3'd5, 3'd3, 11'h2A5, 1'b1);
        repeat (12) @(negedge clk);
        nvec++; if (diagLoadFunc06X !== 1'b1 || diagFunc !== 3'b011) begin nfail++; $display("FAIL arst_pre: got stb %b func %b want 1 011", diagLoadFunc06X, diagFunc); end
        #2 resetN = 1'b0;
        #1;
        nvec++; if ({diagLoadFunc06X, ebusOE, busy, done, loadIR, loadDRAM} !== 6'b0 || reqReady !== 1'b1)
            begin nfail++; $display("FAIL arst_outs: got %b ready %b want 000000 1", {diagLoadFunc06X, ebusOE, busy, done, loadIR, loadDRAM}, reqReady); end
        nvec++; if ({diagFunc, ebusOut, irData} !== 22'h0) begin nfail++; $display("FAIL arst_data: got %h want 0", {diagFunc, ebusOut, irData}); end
        @(negedge clk) resetN = 1'b1;
        test_odd_nojcom("after_arst");
    endtask

`ifdef DRAM_VERIFY_EN
    // RDAB returns 0x2A against expected 0x2B: err set at done, cleared on next accept.
    task automatic test_verify_err;
        rdAB = 6'h2A; rdJ = 6'h05;
        send(9'h054, 3'd5, 3'd3, 11'h2A5, 1'b1);
        watch(22, 0, 0, -1);
        nvec++; if (cDoneCyc !== 19 || cErrDone !== 1'b1) begin nfail++; $display("FAIL verify_err: got cyc %0d err %b want 19 1", cDoneCyc, cErrDone); end
        nvec++; if (err !== 1'b1) begin nfail++; $display("FAIL verify_sticky: got %b want 1", err); end
        test_odd_nojcom("verify_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_even_jcom();
        test_odd_nojcom("odd");
        test_abort();
        test_busy_ignore();
        test_async_reset();
`ifdef DRAM_VERIFY_EN
        test_verify_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
